// File: rtl/uart_dec_printer_pkg.sv
// uart_dec_printer_pkg: shared state/phase encodings and ASCII constants
// for the decimal printer.
package uart_dec_printer_pkg;

    // Printer control states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONVERT = 3'd1,
        ST_SKIP    = 3'd2,
        ST_LOAD    = 3'd3,
        ST_WAIT    = 3'd4,
        ST_SEND    = 3'd5,
        ST_NEXT    = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    // Which kind of character the LOAD state emits next.
    typedef enum logic [1:0] {
        PH_DIGIT = 2'd0,
        PH_CR    = 2'd1,
        PH_LF    = 2'd2
    } phase_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

endpackage

// File: rtl/uart_dec_printer_if.sv
// uart_dec_printer_if: request side (start/value/busy/done) and uart side
// (transmit/tx_byte/is_transmitting) of the decimal printer.
interface uart_dec_printer_if #(parameter int WIDTH = 16);
    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic             transmit;
    logic [7:0]       tx_byte;
    logic             is_transmitting;

    // Environment: control FSM plus the uart status flag.
    modport master (
        output start, value, is_transmitting,
        input  busy, done, transmit, tx_byte
    );

    // The printer itself.
    modport slave (
        input  start, value, is_transmitting,
        output busy, done, transmit, tx_byte
    );
endinterface

// File: rtl/uart_dec_printer_bin2bcd.sv
// bin2bcd_seq: iterative double-dabble converter, one bit per cycle.
// 'last' is high during the final step so the caller can move on with the
// BCD result valid in the very next cycle.
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  last,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int BCD_W = 4 * DIGITS;

    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic [BCD_W-1:0] adj;

    // Add 3 to every nibble >= 5 ahead of the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        assign adj[4*g +: 4] = (bcd[4*g +: 4] >= 4'd5) ? bcd[4*g +: 4] + 4'd3
                                                       : bcd[4*g +: 4];
    end

    assign last = busy && (cnt == CNT_W'(WIDTH - 1));

    // Load clears the result; each busy cycle shifts in the next MSB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            bcd   <= '0;
        end else if (load) begin
            shreg <= bin_in;
            cnt   <= '0;
            busy  <= 1'b1;
            bcd   <= '0;
        end else if (busy) begin
            bcd   <= {adj[BCD_W-2:0], shreg[WIDTH-1]};
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            cnt   <= cnt + 1'b1;
            if (last) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/uart_dec_printer.sv
// uart_dec_printer: prints an unsigned value as decimal ASCII through the
// shared uart, most-significant digit first, without leading zeros.
// Build option: define UART_DEC_PRINTER_CRLF_EN to append CR LF after the
// last digit.
module uart_dec_printer
    import uart_dec_printer_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    uart_dec_printer_if.slave    bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    state_t               state;
    phase_t               phase;
    logic [IDX_W-1:0]     idx;
    logic                 busy_q, done_q, tx_q;
    logic [7:0]           byte_q;
    logic                 conv_load, conv_busy, conv_last;
    logic [4*DIGITS-1:0]  bcd;
    logic [3:0]           cur_digit;

    assign conv_load = (state == ST_IDLE) && bus.start;
    assign cur_digit = bcd[{idx, 2'b00} +: 4];

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.transmit = tx_q;
    assign bus.tx_byte  = byte_q;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_conv (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (conv_load),
        .bin_in  (bus.value),
        .busy    (conv_busy),
        .last    (conv_last),
        .bcd     (bcd)
    );

    // Digit-index and transmit handshake FSM with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            phase  <= PH_DIGIT;
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            tx_q   <= 1'b0;
            byte_q <= 8'h00;
        end else begin
            done_q <= 1'b0;
            tx_q   <= 1'b0;
            case (state)
                ST_IDLE: if (bus.start) begin
                    busy_q <= 1'b1;
                    phase  <= PH_DIGIT;
                    state  <= ST_CONVERT;
                end
                ST_CONVERT: if (conv_last) begin
                    idx   <= IDX_MAX;
                    state <= ST_SKIP;
                end
                // Digit 0 is never skipped, so zero still prints one char.
                ST_SKIP: if (cur_digit == 4'd0 && idx != '0) idx <= idx - 1'b1;
                         else state <= ST_LOAD;
                ST_LOAD: begin
                    tx_q <= 1'b1;
                    case (phase)
                        PH_CR:   byte_q <= ASCII_CR;
                        PH_LF:   byte_q <= ASCII_LF;
                        default: byte_q <= ASCII_ZERO + {4'h0, cur_digit};
                    endcase
                    state <= ST_WAIT;
                end
                ST_WAIT: if (bus.is_transmitting) state <= ST_SEND;
                ST_SEND: if (!bus.is_transmitting) state <= ST_NEXT;
                ST_NEXT: begin
                    if (phase == PH_DIGIT && idx != '0) begin
                        idx   <= idx - 1'b1;
                        state <= ST_LOAD;
                    end
`ifdef UART_DEC_PRINTER_CRLF_EN
                    else if (phase == PH_DIGIT) begin
                        phase <= PH_CR;
                        state <= ST_LOAD;
                    end else if (phase == PH_CR) begin
                        phase <= PH_LF;
                        state <= ST_LOAD;
                    end
`endif
                    else begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Converter busy is implied by the CONVERT state; kept for visibility.
    logic unused_ok;
    assign unused_ok = conv_busy;
endmodule

// File: tb/tb_uart_dec_printer.sv
// tb_uart_dec_printer: directed scenarios against a string-level model of
// the printed text, with a uart model answering each transmit.
module tb_uart_dec_printer;
    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;
`ifdef UART_DEC_PRINTER_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_dec_printer_if #(.WIDTH(WIDTH)) bus();

    uart_dec_printer #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // uart model: busy 2 cycles after transmit, for 20 cycles; logs bytes
    int tx_cnt = 0;
    logic [7:0] got_q[$];
    assign bus.is_transmitting = (tx_cnt >= 3);
    always @(posedge clk) begin
        if (bus.transmit) begin
            got_q.push_back(bus.tx_byte);
            tx_cnt <= 1;
        end else if (tx_cnt == 22) tx_cnt <= 0;
        else if (tx_cnt > 0) tx_cnt <= tx_cnt + 1;
    end

    // model: text expected from the accepted value
    logic [7:0] exp_q[$];
    bit op_active = 1'b0;
    bit first_tx  = 1'b0;
    int n_done  = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    function automatic void push_expected(input int unsigned v);
        string s;
        s = $sformatf("%0d", v);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        if (CRLF) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            exp_q.delete();
            op_active = 1'b0;
            first_tx  = 1'b0;
            if (cyc > 1) begin
                check("rst_busy", bus.busy, 0);
                check("rst_done", bus.done, 0);
                check("rst_transmit", bus.transmit, 0);
                check("rst_tx_byte", bus.tx_byte, 8'h00);
            end
        end else begin
            if (bus.done) begin
                check("done_in_op", op_active, 1);
                check("done_all_bytes_sent", exp_q.size(), 0);
                n_done++;
                op_active = 1'b0;
            end
            check("busy", bus.busy, op_active);
            if (bus.transmit) begin
                if (exp_q.size() == 0) check("extra_transmit", 1, 0);
                else check("tx_byte", bus.tx_byte, exp_q.pop_front());
                if (first_tx) begin
                    first_tx = 1'b0;
                    check("first_tx_latency_ok", (cyc - acc_cyc) >= WIDTH + 2, 1);
                end
            end
            if (bus.start && !op_active) begin
                push_expected(bus.value);
                op_active = 1'b1;
                first_tx  = 1'b1;
                acc_cyc   = cyc;
            end
        end
    end

    task automatic pulse_start(input logic [WIDTH-1:0] v);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.value = v;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.value = WIDTH'($urandom);
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int i = 0; i < budget && n_done == d0; i++) @(negedge clk);
        check("done_seen", n_done, d0 + 1);
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int i = 0; i < budget && got_q.size() < n; i++) @(negedge clk);
        check("bytes_arrived", got_q.size() >= n, 1);
    endtask

    // hand-written expected byte strings
    task automatic check_lit(input string name, input int base, input logic [7:0] lit[$]);
        check({name, "_count"}, got_q.size() - base, lit.size());
        for (int i = 0; i < lit.size(); i++)
            if (base + i < got_q.size()) check(name, got_q[base + i], lit[i]);
    endtask

    function automatic void add_crlf(inout logic [7:0] q[$]);
        if (CRLF) begin
            q.push_back(8'h0D);
            q.push_back(8'h0A);
        end
    endfunction

    initial begin
        logic [7:0] lit[$];
        int base, d0;
        bus.start = 1'b0;
        bus.value = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // value 0 -> "0"
        base = got_q.size(); d0 = n_done;
        pulse_start(16'd0);
        wait_done(d0, 1000);
        lit = '{8'h30}; add_crlf(lit);
        check_lit("v0", base, lit);

        // value 65535 -> "65535"
        base = got_q.size(); d0 = n_done;
        pulse_start(16'hFFFF);
        wait_done(d0, 2000);
        lit = '{8'h36, 8'h35, 8'h35, 8'h33, 8'h35}; add_crlf(lit);
        check_lit("v65535", base, lit);

        // value 1000 -> "1000"
        base = got_q.size(); d0 = n_done;
        pulse_start(16'd1000);
        wait_done(d0, 2000);
        lit = '{8'h31, 8'h30, 8'h30, 8'h30}; add_crlf(lit);
        check_lit("v1000", base, lit);

        // value 42 with an ignored start(7) while waiting on the uart
        base = got_q.size(); d0 = n_done;
        pulse_start(16'd42);
        wait_bytes(base + 1, 500);
        pulse_start(16'd7);
        wait_done(d0, 2000);
        lit = '{8'h34, 8'h32}; add_crlf(lit);
        check_lit("v42_ignore7", base, lit);

        // reset while the uart sends the 2nd digit of 123
        base = got_q.size(); d0 = n_done;
        pulse_start(16'd123);
        wait_bytes(base + 2, 500);
        repeat (6) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("rst_now_transmit", bus.transmit, 0);
        check("rst_now_busy", bus.busy, 0);
        repeat (30) @(posedge clk);
        #1 reset_n = 1'b1;
        check("rst_no_done", n_done, d0);
        lit = '{8'h31, 8'h32};
        check_lit("v123_cut", base, lit);

        // fresh start after reset
        base = got_q.size(); d0 = n_done;
        pulse_start(16'd9);
        wait_done(d0, 1000);
        lit = '{8'h39}; add_crlf(lit);
        check_lit("v9", base, lit);

        // back-to-back: 5, then 10 issued the cycle after done
        base = got_q.size(); d0 = n_done;
        pulse_start(16'd5);
        for (int i = 0; i < 1000 && !bus.done; i++) @(negedge clk);
        check("b2b_first_done", bus.done, 1);
        pulse_start(16'd10);
        wait_done(d0 + 1, 2000);
        lit = '{8'h35}; add_crlf(lit);
        lit.push_back(8'h31); lit.push_back(8'h30); add_crlf(lit);
        check_lit("b2b", base, lit);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
